// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - Register map, ID word, bus FSM states and lane helpers for the Wishbone GPIO bridge.
package wb_gpio_pkg;

   localparam logic [7:0] REG_OUT_LO     = 8'h00;
   localparam logic [7:0] REG_OUT_HI     = 8'h04;
   localparam logic [7:0] REG_OEB_LO     = 8'h08;
   localparam logic [7:0] REG_OEB_HI     = 8'h0C;
   localparam logic [7:0] REG_IN_LO      = 8'h10;
   localparam logic [7:0] REG_IN_HI      = 8'h14;
   localparam logic [7:0] REG_RISE_EN_LO = 8'h18;
   localparam logic [7:0] REG_RISE_EN_HI = 8'h1C;
   localparam logic [7:0] REG_FALL_EN_LO = 8'h20;
   localparam logic [7:0] REG_FALL_EN_HI = 8'h24;
   localparam logic [7:0] REG_STATUS_LO  = 8'h28;
   localparam logic [7:0] REG_STATUS_HI  = 8'h2C;
   localparam logic [7:0] REG_ID         = 8'h30;

   localparam logic [15:0] ID_MAGIC = 16'hB00B;
   localparam logic [7:0]  ID_REV   = 8'h01;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_state_t;

   function automatic logic [31:0] id_word(input logic [7:0] num_gpio);
      return {ID_MAGIC, num_gpio, ID_REV};
   endfunction

   function automatic logic [63:0] low_mask(input int unsigned n);
      if (n >= 64) return {64{1'b1}};
      return (64'd1 << n) - 64'd1;
   endfunction

   // Replace the byte lanes picked by sel in either the LO or HI word.
   function automatic logic [63:0] lane_merge(input logic [63:0] cur, input logic hi,
                                              input logic [3:0] sel, input logic [31:0] wd);
      logic [63:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            if (hi) r[32 + 8*b +: 8] = wd[8*b +: 8];
            else    r[8*b +: 8]      = wd[8*b +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] w1c_mask(input logic hi, input logic [3:0] sel,
                                            input logic [31:0] wd);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            if (hi) r[32 + 8*b +: 8] = wd[8*b +: 8];
            else    r[8*b +: 8]      = wd[8*b +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_gpio_bridge_if.sv
// rtl/wb_gpio_bridge_if.sv - Wishbone slave-port bundle between the wrapper and the GPIO bridge.
interface wb_gpio_bridge_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/gpio_edge_sync.sv
// rtl/gpio_edge_sync.sv - Per-pin input synchroniser with a history flop for rise/fall detection.
module gpio_edge_sync #(
   parameter int unsigned W      = 38,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] sync_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [W-1:0] stage_q [STAGES];
   logic [W-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
         prev_q <= '0;
      end else begin
         stage_q[0] <= din_i;
         for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign sync_o = stage_q[STAGES-1];
   assign rise_o = sync_o & ~prev_q;
   assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/wb_gpio_bridge.sv
// rtl/wb_gpio_bridge.sv - Wishbone-slave GPIO controller: OUT/OEB/IN registers, edge-latched STATUS and level IRQ.
module wb_gpio_bridge
   import wb_gpio_pkg::*;
#(
   parameter int unsigned NUM_GPIO      = 38,
   parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
   parameter logic [63:0] RESERVED_MASK = 64'h1E,
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   wb_gpio_bridge_if.slave     wbs,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oeb,
   output logic                irq
);

   localparam logic [63:0] VALID   = low_mask(NUM_GPIO);
   localparam logic [63:0] LIVE    = VALID & ~RESERVED_MASK;
   localparam logic [31:0] ID_VAL  = id_word(8'(NUM_GPIO));
   localparam logic [1:0]  WS_LAST = 2'(WAIT_STATES - 1);

   wb_state_t   state_q;
   logic [1:0]  cnt_q;
   logic [7:2]  adr_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] wdat_q;
   logic        ack_q;
   logic [31:0] dat_q;

   logic [63:0] out_q, out_d;
   logic [63:0] oeb_q, oeb_d;
   logic [63:0] rise_en_q, rise_en_d;
   logic [63:0] fall_en_q, fall_en_d;
   logic [63:0] status_q, status_d;
   logic        irq_q;

   logic [NUM_GPIO-1:0] sync_w, rise_w, fall_w;
   logic [63:0] in64, set_v, clr;
   logic        active, hit;
   logic [7:2]  rd_adr;
   logic [7:0]  rd_ofs, wr_base;
   logic        wr_hi;
   logic [31:0] rd_data;
   logic        unused_adr;

   gpio_edge_sync #(.W(NUM_GPIO), .STAGES(SYNC_STAGES)) u_sync (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .din_i  (gpio_in),
      .sync_o (sync_w),
      .rise_o (rise_w),
      .fall_o (fall_w)
   );

   assign in64  = 64'(sync_w) & LIVE;
   assign set_v = ((64'(rise_w) & rise_en_q) | (64'(fall_w) & fall_en_q)) & LIVE;

   assign active     = wbs.wbs_stb_i & wbs.wbs_cyc_i;
   assign hit        = active & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign unused_adr = ^wbs.wbs_adr_i[1:0];

   // With zero wait states the read is answered straight from the live address.
   assign rd_adr  = (state_q == IDLE) ? wbs.wbs_adr_i[7:2] : adr_q;
   assign rd_ofs  = {rd_adr, 2'b00};
   assign wr_base = {adr_q[7:3], 3'b000};
   assign wr_hi   = adr_q[2];

   always_comb begin
      rd_data = '0;
      case (rd_ofs)
         REG_OUT_LO:     rd_data = out_q[31:0];
         REG_OUT_HI:     rd_data = out_q[63:32];
         REG_OEB_LO:     rd_data = oeb_q[31:0];
         REG_OEB_HI:     rd_data = oeb_q[63:32];
         REG_IN_LO:      rd_data = in64[31:0];
         REG_IN_HI:      rd_data = in64[63:32];
         REG_RISE_EN_LO: rd_data = rise_en_q[31:0];
         REG_RISE_EN_HI: rd_data = rise_en_q[63:32];
         REG_FALL_EN_LO: rd_data = fall_en_q[31:0];
         REG_FALL_EN_HI: rd_data = fall_en_q[63:32];
         REG_STATUS_LO:  rd_data = status_q[31:0];
         REG_STATUS_HI:  rd_data = status_q[63:32];
         REG_ID:         rd_data = ID_VAL;
         default:        rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdat_q  <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  adr_q  <= wbs.wbs_adr_i[7:2];
                  we_q   <= wbs.wbs_we_i;
                  sel_q  <= wbs.wbs_sel_i;
                  wdat_q <= wbs.wbs_dat_i;
                  cnt_q  <= '0;
                  if (WAIT_STATES == 0) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                     dat_q   <= rd_data;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (!active) begin
                  state_q <= IDLE;
               end else if (cnt_q == WS_LAST) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  dat_q   <= rd_data;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            ACK: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               dat_q   <= '0;
            end
         endcase
      end
   end

   // Writes commit on the edge that closes the ack cycle; a STATUS set beats a same-edge clear.
   always_comb begin
      out_d     = out_q;
      oeb_d     = oeb_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      if (state_q == ACK && we_q) begin
         case (wr_base)
            REG_OUT_LO:     out_d     = lane_merge(out_q, wr_hi, sel_q, wdat_q) & VALID;
            REG_OEB_LO:     oeb_d     = lane_merge(oeb_q, wr_hi, sel_q, wdat_q) & VALID;
            REG_RISE_EN_LO: rise_en_d = lane_merge(rise_en_q, wr_hi, sel_q, wdat_q) & VALID;
            REG_FALL_EN_LO: fall_en_d = lane_merge(fall_en_q, wr_hi, sel_q, wdat_q) & VALID;
            REG_STATUS_LO:  clr       = w1c_mask(wr_hi, sel_q, wdat_q);
            default:        clr       = '0;
         endcase
      end
      status_d = (status_q & ~clr) | set_v;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         out_q     <= '0;
         oeb_q     <= VALID;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         oeb_q     <= oeb_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         irq_q     <= |(status_q & (rise_en_q | fall_en_q));
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = dat_q;
   assign gpio_out      = out_q[NUM_GPIO-1:0] & LIVE[NUM_GPIO-1:0];
   assign gpio_oeb      = oeb_q[NUM_GPIO-1:0] | ~LIVE[NUM_GPIO-1:0];
   assign irq           = irq_q;

endmodule

// File: tb/tb_wb_gpio_bridge.sv
// tb/tb_wb_gpio_bridge.sv - Directed table-driven bench for wb_gpio_bridge with zero and three wait states.
module tb_wb_gpio_bridge;

   localparam int NG = 38;
   localparam logic [NG-1:0] ONES = {NG{1'b1}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_gpio_bridge_if bus0();
   wb_gpio_bridge_if bus3();

   logic [NG-1:0] gin0, gout0, goeb0, gin3, gout3, goeb3;
   logic          irq0, irq3;

   wb_gpio_bridge #(.NUM_GPIO(NG)) dut0 (
      .wb_clk_i (clk), .wb_rst_i (rst), .wbs (bus0.slave),
      .gpio_in  (gin0), .gpio_out (gout0), .gpio_oeb (goeb0), .irq (irq0)
   );

   wb_gpio_bridge #(.NUM_GPIO(NG), .WAIT_STATES(3)) dut3 (
      .wb_clk_i (clk), .wb_rst_i (rst), .wbs (bus3.slave),
      .gpio_in  (gin3), .gpio_out (gout3), .gpio_oeb (goeb3), .irq (irq3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wb0(input logic we, input logic [7:0] ofs, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
      @(negedge clk);
      bus0.wbs_stb_i = 1'b1; bus0.wbs_cyc_i = 1'b1; bus0.wbs_we_i = we;
      bus0.wbs_sel_i = sel;  bus0.wbs_adr_i = 32'h3000_0000 | 32'(ofs); bus0.wbs_dat_i = wd;
      lat = 0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus0.wbs_ack_o) begin lat = i; rd = bus0.wbs_dat_o; break; end
      end
      bus0.wbs_stb_i = 1'b0; bus0.wbs_cyc_i = 1'b0; bus0.wbs_we_i = 1'b0;
      if (lat == 0) chk($sformatf("dut0 ack timeout ofs=%h", ofs), 64'd0, 64'd1);
   endtask

   task automatic wb3(input logic we, input logic [7:0] ofs, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
      @(negedge clk);
      bus3.wbs_stb_i = 1'b1; bus3.wbs_cyc_i = 1'b1; bus3.wbs_we_i = we;
      bus3.wbs_sel_i = sel;  bus3.wbs_adr_i = 32'h3000_0000 | 32'(ofs); bus3.wbs_dat_i = wd;
      lat = 0; rd = '0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus3.wbs_ack_o) begin lat = i; rd = bus3.wbs_dat_o; break; end
      end
      bus3.wbs_stb_i = 1'b0; bus3.wbs_cyc_i = 1'b0; bus3.wbs_we_i = 1'b0;
      if (lat == 0) chk($sformatf("dut3 ack timeout ofs=%h", ofs), 64'd0, 64'd1);
   endtask

   typedef struct {
      logic          we;
      logic [7:0]    ofs;
      logic [3:0]    sel;
      logic [31:0]   wd;
      logic [31:0]   exp_rd;
      logic          pins;
      logic [NG-1:0] exp_out;
      logic [NG-1:0] exp_oeb;
   } vec_t;

   vec_t vt[19];

   initial begin
      #2_000_000;
      $display("FAIL global timeout");
      $fatal(1, "bench stalled");
   end

   initial begin
      logic [31:0] rd;
      int          lat, acks;
      logic [15:0] ack_mask;
      logic        nz;

      vt[0]  = '{1'b0, 8'h30, 4'hF, 32'h0,         32'hB00B_2601, 1'b1, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
      vt[1]  = '{1'b1, 8'h08, 4'h3, 32'h0,         32'h0,         1'b1, 38'h00_0000_0000, 38'h3F_FFFF_001E};
      vt[2]  = '{1'b1, 8'h00, 4'h3, 32'hFFFF_FFFF, 32'h0,         1'b1, 38'h00_0000_FFE1, 38'h3F_FFFF_001E};
      vt[3]  = '{1'b0, 8'h00, 4'hF, 32'h0,         32'h0000_FFFF, 1'b0, '0, '0};
      vt[4]  = '{1'b0, 8'h08, 4'hF, 32'h0,         32'hFFFF_0000, 1'b0, '0, '0};
      vt[5]  = '{1'b0, 8'h0C, 4'hF, 32'h0,         32'h0000_003F, 1'b0, '0, '0};
      vt[6]  = '{1'b1, 8'h04, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 38'h3F_0000_FFE1, 38'h3F_FFFF_001E};
      vt[7]  = '{1'b0, 8'h04, 4'hF, 32'h0,         32'h0000_003F, 1'b0, '0, '0};
      vt[8]  = '{1'b1, 8'h0C, 4'h1, 32'h0,         32'h0,         1'b1, 38'h3F_0000_FFE1, 38'h00_FFFF_001E};
      vt[9]  = '{1'b1, 8'h40, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 38'h3F_0000_FFE1, 38'h00_FFFF_001E};
      vt[10] = '{1'b0, 8'h40, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};
      vt[11] = '{1'b0, 8'h34, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};
      vt[12] = '{1'b0, 8'h10, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};
      vt[13] = '{1'b1, 8'h28, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0, '0, '0};
      vt[14] = '{1'b0, 8'h28, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};
      vt[15] = '{1'b1, 8'h18, 4'h4, 32'hAABB_CCDD, 32'h0,         1'b0, '0, '0};
      vt[16] = '{1'b0, 8'h18, 4'hF, 32'h0,         32'h00BB_0000, 1'b0, '0, '0};
      vt[17] = '{1'b1, 8'h18, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};
      vt[18] = '{1'b0, 8'h18, 4'hF, 32'h0,         32'h0,         1'b0, '0, '0};

      rst = 1'b1; gin0 = '0; gin3 = '0;
      bus0.wbs_stb_i = 0; bus0.wbs_cyc_i = 0; bus0.wbs_we_i = 0; bus0.wbs_sel_i = 0;
      bus0.wbs_adr_i = 0; bus0.wbs_dat_i = 0;
      bus3.wbs_stb_i = 0; bus3.wbs_cyc_i = 0; bus3.wbs_we_i = 0; bus3.wbs_sel_i = 0;
      bus3.wbs_adr_i = 0; bus3.wbs_dat_i = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset gpio_out",  64'(gout0), 64'(0));
      chk("reset gpio_oeb",  64'(goeb0), 64'(ONES));
      chk("reset irq",       64'(irq0), 64'(0));
      chk("reset ack",       64'(bus0.wbs_ack_o), 64'(0));
      chk("reset dat",       64'(bus0.wbs_dat_o), 64'(0));
      chk("reset ws3 oeb",   64'(goeb3), 64'(ONES));

      foreach (vt[i]) begin
         wb0(vt[i].we, vt[i].ofs, vt[i].sel, vt[i].wd, rd, lat);
         chk($sformatf("vec%0d latency", i), 64'(lat), 64'(1));
         if (!vt[i].we) chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(vt[i].exp_rd));
         if (vt[i].pins) begin
            @(negedge clk);
            chk($sformatf("vec%0d gpio_out", i), 64'(gout0), 64'(vt[i].exp_out));
            chk($sformatf("vec%0d gpio_oeb", i), 64'(goeb0), 64'(vt[i].exp_oeb));
         end
      end

      // IN register masks reserved pins; no edges enabled so nothing latches.
      gin0 = 38'h2A_0000_00FF;
      repeat (4) @(negedge clk);
      wb0(1'b0, 8'h10, 4'hF, 32'h0, rd, lat); chk("in lo", 64'(rd), 64'h0000_00E1);
      wb0(1'b0, 8'h14, 4'hF, 32'h0, rd, lat); chk("in hi", 64'(rd), 64'h0000_002A);
      wb0(1'b0, 8'h28, 4'hF, 32'h0, rd, lat); chk("status no enable", 64'(rd), 64'h0);
      chk("irq no enable", 64'(irq0), 64'(0));
      gin0 = '0;
      repeat (4) @(negedge clk);

      // Rising edge on pin 5 (enabled) and reserved pin 2 (enabled, must be ignored).
      wb0(1'b1, 8'h18, 4'hF, 32'h24, rd, lat);
      @(negedge clk);
      gin0[5] = 1'b1; gin0[2] = 1'b1;
      repeat (3) @(negedge clk);
      chk("irq latency early", 64'(irq0), 64'(0));
      @(negedge clk);
      chk("irq latency", 64'(irq0), 64'(1));
      wb0(1'b0, 8'h28, 4'hF, 32'h0, rd, lat); chk("status rise", 64'(rd), 64'h20);
      wb0(1'b1, 8'h28, 4'hF, 32'h20, rd, lat);
      repeat (2) @(negedge clk);
      chk("irq after w1c", 64'(irq0), 64'(0));
      wb0(1'b0, 8'h28, 4'hF, 32'h0, rd, lat); chk("status after w1c", 64'(rd), 64'h0);

      // W1C commit edge coincides with a fresh rising edge: set must win.
      gin0[5] = 1'b0; repeat (5) @(negedge clk);
      gin0[5] = 1'b1; repeat (5) @(negedge clk);
      chk("irq before race", 64'(irq0), 64'(1));
      gin0[5] = 1'b0; repeat (5) @(negedge clk);
      gin0[5] = 1'b1;
      wb0(1'b1, 8'h28, 4'hF, 32'h20, rd, lat);
      repeat (2) @(negedge clk);
      chk("irq set wins", 64'(irq0), 64'(1));
      wb0(1'b0, 8'h28, 4'hF, 32'h0, rd, lat); chk("status set wins", 64'(rd), 64'h20);
      wb0(1'b1, 8'h18, 4'hF, 32'h0, rd, lat);
      wb0(1'b1, 8'h28, 4'hF, 32'h20, rd, lat);

      // Falling edge in the HI word, then enable removed while status stays latched.
      gin0[32] = 1'b1; repeat (5) @(negedge clk);
      wb0(1'b1, 8'h24, 4'h1, 32'h1, rd, lat);
      gin0[32] = 1'b0; repeat (5) @(negedge clk);
      chk("irq fall", 64'(irq0), 64'(1));
      wb0(1'b0, 8'h2C, 4'hF, 32'h0, rd, lat); chk("status fall hi", 64'(rd), 64'h1);
      wb0(1'b1, 8'h24, 4'hF, 32'h0, rd, lat);
      repeat (2) @(negedge clk);
      chk("irq enable cleared", 64'(irq0), 64'(0));
      wb0(1'b0, 8'h2C, 4'hF, 32'h0, rd, lat); chk("status kept", 64'(rd), 64'h1);
      wb0(1'b1, 8'h2C, 4'h0, 32'h1, rd, lat);
      wb0(1'b0, 8'h2C, 4'hF, 32'h0, rd, lat); chk("w1c sel=0 ignored", 64'(rd), 64'h1);
      wb0(1'b1, 8'h2C, 4'h1, 32'h1, rd, lat);
      wb0(1'b0, 8'h2C, 4'hF, 32'h0, rd, lat); chk("w1c sel=1", 64'(rd), 64'h0);
      gin0[32] = 1'b1; repeat (5) @(negedge clk);
      gin0[32] = 1'b0; repeat (5) @(negedge clk);
      wb0(1'b0, 8'h2C, 4'hF, 32'h0, rd, lat); chk("disabled edge", 64'(rd), 64'h0);

      // Out-of-window address and cyc low must never ack.
      @(negedge clk);
      bus0.wbs_stb_i = 1'b1; bus0.wbs_cyc_i = 1'b1; bus0.wbs_adr_i = 32'h3000_0100;
      acks = 0;
      repeat (5) begin @(negedge clk); if (bus0.wbs_ack_o) acks++; end
      chk("no ack outside window", 64'(acks), 64'(0));
      bus0.wbs_cyc_i = 1'b0; bus0.wbs_adr_i = 32'h3000_0030;
      acks = 0;
      repeat (5) begin @(negedge clk); if (bus0.wbs_ack_o) acks++; end
      chk("no ack cyc low", 64'(acks), 64'(0));
      bus0.wbs_stb_i = 1'b0;

      // Three wait states, stb held for two back-to-back reads.
      wb3(1'b0, 8'h30, 4'hF, 32'h0, rd, lat);
      chk("ws3 latency", 64'(lat), 64'(4));
      chk("ws3 id", 64'(rd), 64'hB00B_2601);
      @(negedge clk);
      bus3.wbs_stb_i = 1'b1; bus3.wbs_cyc_i = 1'b1; bus3.wbs_we_i = 1'b0;
      bus3.wbs_sel_i = 4'hF; bus3.wbs_adr_i = 32'h3000_0030;
      ack_mask = '0; nz = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (bus3.wbs_ack_o) begin
            ack_mask[i] = 1'b1;
            chk($sformatf("ws3 b2b dat %0d", i), 64'(bus3.wbs_dat_o), 64'hB00B_2601);
         end else if (bus3.wbs_dat_o != 0) begin
            nz = 1'b1;
         end
         if (i == 10) begin bus3.wbs_stb_i = 1'b0; bus3.wbs_cyc_i = 1'b0; end
      end
      chk("ws3 b2b ack pattern", 64'(ack_mask), 64'h0210);
      chk("ws3 dat zero without ack", 64'(nz), 64'(0));

      // Abort in WAIT: no ack and no write.
      @(negedge clk);
      bus3.wbs_stb_i = 1'b1; bus3.wbs_cyc_i = 1'b1; bus3.wbs_we_i = 1'b1;
      bus3.wbs_sel_i = 4'hF; bus3.wbs_adr_i = 32'h3000_0000; bus3.wbs_dat_i = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      bus3.wbs_stb_i = 1'b0; bus3.wbs_cyc_i = 1'b0; bus3.wbs_we_i = 1'b0;
      acks = 0;
      repeat (8) begin @(negedge clk); if (bus3.wbs_ack_o) acks++; end
      chk("abort no ack", 64'(acks), 64'(0));
      chk("abort gpio_out", 64'(gout3), 64'(0));
      wb3(1'b0, 8'h00, 4'hF, 32'h0, rd, lat); chk("abort out reg", 64'(rd), 64'h0);

      // Reset asserted during WAIT of an OUT write.
      @(negedge clk);
      bus3.wbs_stb_i = 1'b1; bus3.wbs_cyc_i = 1'b1; bus3.wbs_we_i = 1'b1;
      bus3.wbs_sel_i = 4'hF; bus3.wbs_adr_i = 32'h3000_0000; bus3.wbs_dat_i = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus3.wbs_stb_i = 1'b0; bus3.wbs_cyc_i = 1'b0; bus3.wbs_we_i = 1'b0;
      chk("rst ack", 64'(bus3.wbs_ack_o), 64'(0));
      chk("rst dat", 64'(bus3.wbs_dat_o), 64'(0));
      chk("rst gpio_out", 64'(gout3), 64'(0));
      chk("rst gpio_oeb", 64'(goeb3), 64'(ONES));
      chk("rst irq", 64'(irq3), 64'(0));
      chk("rst dut0 oeb", 64'(goeb0), 64'(ONES));
      chk("rst dut0 out", 64'(gout0), 64'(0));
      acks = 0;
      repeat (6) begin @(negedge clk); if (bus3.wbs_ack_o) acks++; end
      chk("rst no late ack", 64'(acks), 64'(0));
      wb3(1'b0, 8'h00, 4'hF, 32'h0, rd, lat); chk("rst write lost", 64'(rd), 64'h0);
      wb0(1'b0, 8'h08, 4'hF, 32'h0, rd, lat); chk("rst oeb reg", 64'(rd), 64'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
